// File: rtl/gpu_draw_sched_if.sv
// Command bus between the host/command decoder and the draw scheduler.
// The master drives a command and its valid; the slave answers with ready.
interface gpu_draw_sched_if #(
  parameter int unsigned WIDTH_BITS   = 10,
  parameter int unsigned HEIGHT_BITS  = 9,
  parameter int unsigned CHANNEL_BITS = 8
) ();
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [1:0]              cmd_op;
  logic [WIDTH_BITS-1:0]   cmd_x1;
  logic [WIDTH_BITS-1:0]   cmd_x2;
  logic [HEIGHT_BITS-1:0]  cmd_y1;
  logic [HEIGHT_BITS-1:0]  cmd_y2;
  logic [CHANNEL_BITS-1:0] cmd_r;
  logic [CHANNEL_BITS-1:0] cmd_g;
  logic [CHANNEL_BITS-1:0] cmd_b;

  modport master (
    output cmd_valid, cmd_op, cmd_x1, cmd_x2, cmd_y1, cmd_y2, cmd_r, cmd_g, cmd_b,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x1, cmd_x2, cmd_y1, cmd_y2, cmd_r, cmd_g, cmd_b,
    output cmd_ready
  );
endinterface

// File: rtl/gpu_draw_sched.sv
// Draw command scheduler for gpu_fill_rect: queues commands, normalises and clamps
// rectangle corners, pulses start and waits for done before issuing the next one.
module gpu_draw_sched #(
  parameter int unsigned WIDTH_BITS   = 10,
  parameter int unsigned HEIGHT_BITS  = 9,
  parameter int unsigned CHANNEL_BITS = 8,
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  gpu_draw_sched_if.slave         cmd,
  input  logic                    flush_i,
  input  logic                    eng_done_i,
  output logic [WIDTH_BITS-1:0]   x1_o,
  output logic [WIDTH_BITS-1:0]   x2_o,
  output logic [HEIGHT_BITS-1:0]  y1_o,
  output logic [HEIGHT_BITS-1:0]  y2_o,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic                    start_o,
  output logic                    idle_o,
  output logic [15:0]             cmd_cnt_o,
  output logic                    bad_cmd_o
);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam logic [WIDTH_BITS-1:0]  XMax = WIDTH_BITS'(SCREEN_W - 1);
  localparam logic [HEIGHT_BITS-1:0] YMax = HEIGHT_BITS'(SCREEN_H - 1);
  localparam logic [1:0] OpFill  = 2'd0;
  localparam logic [1:0] OpClear = 2'd1;
  localparam logic [1:0] OpNop   = 2'd2;

  typedef struct packed {
    logic [1:0]              op;
    logic [WIDTH_BITS-1:0]   x1;
    logic [WIDTH_BITS-1:0]   x2;
    logic [HEIGHT_BITS-1:0]  y1;
    logic [HEIGHT_BITS-1:0]  y2;
    logic [CHANNEL_BITS-1:0] r;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StLoad, StStart, StWait} state_e;

  cmd_t             mem_q [FIFO_DEPTH];
  cmd_t             in_cmd, head;
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             empty, full, push, pop, load_en, cnt_inc;
  state_e           state_q, state_d;

  logic [WIDTH_BITS-1:0]   x1_q, x2_q, lo_x, hi_x;
  logic [HEIGHT_BITS-1:0]  y1_q, y2_q, lo_y, hi_y;
  logic [CHANNEL_BITS-1:0] r_q, g_q, b_q;
  logic [15:0]             cmd_cnt_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign cmd.cmd_ready = !full;
  assign push  = cmd.cmd_valid && !full && !flush_i;

  assign in_cmd = '{op: cmd.cmd_op, x1: cmd.cmd_x1, x2: cmd.cmd_x2, y1: cmd.cmd_y1,
                    y2: cmd.cmd_y2, r: cmd.cmd_r, g: cmd.cmd_g, b: cmd.cmd_b};
  assign head   = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AddrW-1:0]] <= in_cmd;
  end

  // Flush aligns read to the pre-push write pointer, dropping any same-cycle push too.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AddrW{1'b0}}, push};
    rd_ptr_d = flush_i ? wr_ptr_q : rd_ptr_q + {{AddrW{1'b0}}, pop};
  end

  always_comb begin
    lo_x = (head.x1 < head.x2) ? head.x1 : head.x2;
    hi_x = (head.x1 < head.x2) ? head.x2 : head.x1;
    lo_y = (head.y1 < head.y2) ? head.y1 : head.y2;
    hi_y = (head.y1 < head.y2) ? head.y2 : head.y1;
    if (lo_x > XMax) lo_x = XMax;
    if (hi_x > XMax) hi_x = XMax;
    if (lo_y > YMax) lo_y = YMax;
    if (hi_y > YMax) hi_y = YMax;
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load_en   = 1'b0;
    cnt_inc   = 1'b0;
    start_o   = 1'b0;
    bad_cmd_o = 1'b0;
    unique case (state_q)
      StIdle: if (!empty) state_d = StLoad;
      StLoad: begin
        state_d = StIdle;
        // A flush between IDLE and LOAD can leave nothing to pop.
        if (!empty) begin
          pop = 1'b1;
          case (head.op)
            OpFill, OpClear: begin
              load_en = 1'b1;
              state_d = StStart;
            end
            OpNop:   ;
            default: bad_cmd_o = 1'b1;
          endcase
        end
      end
      StStart: begin
        start_o = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (eng_done_i) begin
          cnt_inc = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cmd_cnt_q <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (cnt_inc) cmd_cnt_q <= cmd_cnt_q + 16'd1;
      if (load_en) begin
        r_q <= head.r;
        g_q <= head.g;
        b_q <= head.b;
        if (head.op == OpClear) begin
          x1_q <= '0;
          y1_q <= '0;
          x2_q <= XMax;
          y2_q <= YMax;
        end else begin
          x1_q <= lo_x;
          y1_q <= lo_y;
          x2_q <= hi_x;
          y2_q <= hi_y;
        end
      end
    end
  end

  assign x1_o      = x1_q;
  assign x2_o      = x2_q;
  assign y1_o      = y1_q;
  assign y2_o      = y2_q;
  assign r_o       = r_q;
  assign g_o       = g_q;
  assign b_o       = b_q;
  assign cmd_cnt_o = cmd_cnt_q;
  assign idle_o    = (state_q == StIdle) && empty;
endmodule

// File: tb/tb_gpu_draw_sched.sv
// Directed bench for gpu_draw_sched: hand-computed corners, latency, queueing,
// illegal/NOP handling, flush and reset behaviour.
module tb_gpu_draw_sched;
  logic        tb_clk = 1'b0;
  logic        rst, flush_i, eng_done_i;
  logic [9:0]  x1_o, x2_o;
  logic [8:0]  y1_o, y2_o;
  logic [7:0]  r_o, g_o, b_o;
  logic        start_o, idle_o, bad_cmd_o;
  logic [15:0] cmd_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;
  int start_total = 0;
  int bad_total = 0;
  int exp_cnt;
  int s0, b0;

  always #5 tb_clk = ~tb_clk;

  gpu_draw_sched_if cmd_bus ();

  gpu_draw_sched dut (
    .clk        (tb_clk),
    .rst        (rst),
    .cmd        (cmd_bus),
    .flush_i    (flush_i),
    .eng_done_i (eng_done_i),
    .x1_o       (x1_o),
    .x2_o       (x2_o),
    .y1_o       (y1_o),
    .y2_o       (y2_o),
    .r_o        (r_o),
    .g_o        (g_o),
    .b_o        (b_o),
    .start_o    (start_o),
    .idle_o     (idle_o),
    .cmd_cnt_o  (cmd_cnt_o),
    .bad_cmd_o  (bad_cmd_o)
  );

  always @(negedge tb_clk) begin
    if (start_o) start_total++;
    if (bad_cmd_o) bad_total++;
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] op, input int x1, input int y1, input int x2,
                          input int y2, input int r, input int g, input int b);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_x1    = 10'(x1);
    cmd_bus.cmd_y1    = 9'(y1);
    cmd_bus.cmd_x2    = 10'(x2);
    cmd_bus.cmd_y2    = 9'(y2);
    cmd_bus.cmd_r     = 8'(r);
    cmd_bus.cmd_g     = 8'(g);
    cmd_bus.cmd_b     = 8'(b);
    step();
    cmd_bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (start_o) seen = 1'b1;
      else step();
    end
    check_eq({tag, ".start_seen"}, seen, 1);
  endtask

  task automatic check_eng(input string tag, input int ex1, input int ey1, input int ex2,
                           input int ey2, input int er, input int eg, input int eb);
    check_eq({tag, ".x1"}, x1_o, ex1);
    check_eq({tag, ".y1"}, y1_o, ey1);
    check_eq({tag, ".x2"}, x2_o, ex2);
    check_eq({tag, ".y2"}, y2_o, ey2);
    check_eq({tag, ".r"}, r_o, er);
    check_eq({tag, ".g"}, g_o, eg);
    check_eq({tag, ".b"}, b_o, eb);
  endtask

  task automatic done_pulse();
    eng_done_i = 1'b1;
    step();
    eng_done_i = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eng(tag, 0, 0, 0, 0, 0, 0, 0);
    check_eq({tag, ".start"}, start_o, 0);
    check_eq({tag, ".idle"}, idle_o, 1);
    check_eq({tag, ".ready"}, cmd_bus.cmd_ready, 1);
    check_eq({tag, ".cnt"}, cmd_cnt_o, 0);
    check_eq({tag, ".bad"}, bad_cmd_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    eng_done_i = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op = 2'd0;
    cmd_bus.cmd_x1 = '0;
    cmd_bus.cmd_y1 = '0;
    cmd_bus.cmd_x2 = '0;
    cmd_bus.cmd_y2 = '0;
    cmd_bus.cmd_r = '0;
    cmd_bus.cmd_g = '0;
    cmd_bus.cmd_b = '0;
    step();
    step();
    check_reset_state("reset");
    rst = 1'b0;
    exp_cnt = 0;

    // Basic FILL with exact start latency and hold in WAIT_DONE.
    push_cmd(2'd0, 10, 20, 50, 60, 50, 40, 80);
    check_eq("t1.idle_busy", idle_o, 0);
    step();
    step();
    check_eq("t1.start_lat", start_o, 1);
    check_eng("t1", 10, 20, 50, 60, 50, 40, 80);
    step();
    check_eq("t1.start_pulse", start_o, 0);
    check_eng("t1_hold", 10, 20, 50, 60, 50, 40, 80);
    done_pulse();
    exp_cnt++;
    check_eq("t1.cnt", cmd_cnt_o, exp_cnt);
    check_eq("t1.idle", idle_o, 1);
    done_pulse();
    check_eq("done_ignored.cnt", cmd_cnt_o, exp_cnt);

    // Corner swap, clamping and single-pixel rectangle.
    push_cmd(2'd0, 200, 150, 0, 0, 9, 8, 7);
    wait_start("t2a");
    check_eng("t2a", 0, 0, 200, 150, 9, 8, 7);
    step();
    done_pulse();
    exp_cnt++;
    push_cmd(2'd0, 5, 7, 1000, 500, 1, 1, 1);
    wait_start("t2b");
    check_eng("t2b", 5, 7, 639, 479, 1, 1, 1);
    step();
    done_pulse();
    exp_cnt++;
    push_cmd(2'd0, 1000, 511, 1000, 511, 4, 5, 6);
    wait_start("t2c");
    check_eng("t2c", 639, 479, 639, 479, 4, 5, 6);
    step();
    done_pulse();
    exp_cnt++;
    check_eq("t2.cnt", cmd_cnt_o, exp_cnt);

    // CLEAR ignores coordinates.
    push_cmd(2'd1, 33, 44, 55, 66, 1, 2, 3);
    wait_start("t3");
    check_eng("t3", 0, 0, 639, 479, 1, 2, 3);
    step();
    done_pulse();
    exp_cnt++;
    check_eq("t3.cnt", cmd_cnt_o, exp_cnt);

    // Fill the queue while a command is in flight; the fifth push must be refused.
    push_cmd(2'd0, 1, 1, 2, 2, 0, 0, 0);
    wait_start("t4a");
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check_eq("t4.full_ready", cmd_bus.cmd_ready, 0);
      push_cmd(2'd0, 100 + i, 10, 200, 20, i, 0, 0);
    end
    done_pulse();
    exp_cnt++;
    step();
    step();
    check_eq("t4.next_lat", start_o, 1);
    for (int i = 0; i < 4; i++) begin
      wait_start("t4q");
      check_eng("t4q", 100 + i, 10, 200, 20, i, 0, 0);
      step();
      done_pulse();
      exp_cnt++;
    end
    repeat (5) step();
    check_eq("t4.drained", idle_o, 1);
    check_eq("t4.cnt", cmd_cnt_o, exp_cnt);

    // Illegal op and NOP: one bad pulse, only the FILL starts.
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    s0 = start_total;
    b0 = bad_total;
    push_cmd(2'd3, 1, 2, 3, 4, 5, 6, 7);
    push_cmd(2'd2, 1, 2, 3, 4, 5, 6, 7);
    push_cmd(2'd0, 3, 4, 5, 6, 7, 8, 9);
    wait_start("t5");
    check_eng("t5", 3, 4, 5, 6, 7, 8, 9);
    step();
    done_pulse();
    exp_cnt++;
    repeat (4) step();
    check_eq("t5.bad_pulses", bad_total - b0, 1);
    check_eq("t5.starts", start_total - s0, 1);
    check_eq("t5.cnt", cmd_cnt_o, 1);

    // Flush during WAIT_DONE: in-flight completes, queued entries vanish.
    push_cmd(2'd0, 20, 20, 30, 30, 1, 1, 1);
    wait_start("t6");
    step();
    push_cmd(2'd0, 1, 1, 1, 1, 1, 1, 1);
    push_cmd(2'd0, 2, 2, 2, 2, 2, 2, 2);
    push_cmd(2'd0, 3, 3, 3, 3, 3, 3, 3);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check_eq("t6.inflight", idle_o, 0);
    s0 = start_total;
    done_pulse();
    exp_cnt++;
    repeat (6) step();
    check_eq("t6.idle", idle_o, 1);
    check_eq("t6.no_start", start_total - s0, 0);
    check_eq("t6.cnt", cmd_cnt_o, exp_cnt);

    // Flush beats a same-cycle push.
    flush_i = 1'b1;
    push_cmd(2'd0, 9, 9, 9, 9, 9, 9, 9);
    flush_i = 1'b0;
    repeat (4) step();
    check_eq("flush_push.idle", idle_o, 1);
    check_eq("flush_push.no_start", start_total - s0, 0);

    // Reset during WAIT_DONE abandons the command and the queue.
    push_cmd(2'd0, 11, 12, 13, 14, 15, 16, 17);
    wait_start("t7");
    step();
    push_cmd(2'd0, 40, 40, 50, 50, 1, 1, 1);
    rst = 1'b1;
    step();
    check_reset_state("t7_rst");
    rst = 1'b0;
    s0 = start_total;
    repeat (4) step();
    check_eq("t7.queue_gone", start_total - s0, 0);
    check_eq("t7.idle", idle_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
